// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSD first, with a
// second complementing pass so a negative difference comes out as magnitude plus sign.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic [4*DIGITS-1:0]   result,
    output logic                  ovf,
    output logic                  neg,
    output logic                  err,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(DIGITS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic                op_q, op_d, ovf_q, ovf_d, neg_q, neg_d, err_q, err_d, c_q, c_d;
    logic [IW-1:0]       idx_q, idx_d;

    logic [3:0] a_dig, b_dig, r_dig, add_x, add_y, sum_dig;
    logic [4:0] sum;
    logic       sum_c, bad_digit;

    assign a_dig = a_q[4*int'(idx_q) +: 4];
    assign b_dig = b_q[4*int'(idx_q) +: 4];
    assign r_dig = result_q[4*int'(idx_q) +: 4];

    // One shared digit adder: RUN adds A to B (or its nines' complement),
    // FIX adds the carry to the nines' complement of the partial result.
    always_comb begin
        if (state_q == ST_FIX) begin
            add_x = 4'd9 - r_dig;
            add_y = 4'd0;
        end else begin
            add_x = a_dig;
            add_y = op_q ? (4'd9 - b_dig) : b_dig;
        end
        sum = {1'b0, add_x} + {1'b0, add_y} + {4'b0, c_q};
        if (sum > 5'd9) begin
            sum_dig = sum[3:0] + 4'd6;
            sum_c   = 1'b1;
        end else begin
            sum_dig = sum[3:0];
            sum_c   = 1'b0;
        end
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        err_d    = err_q;
        c_d      = c_q;
        idx_d    = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    neg_d    = 1'b0;
                    err_d    = bad_digit;
                    idx_d    = '0;
                    c_d      = op;
                    state_d  = bad_digit ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[4*int'(idx_q) +: 4] = sum_dig;
                c_d = sum_c;
                if (idx_q == LastIdx) begin
                    if (!op_q) begin
                        ovf_d   = sum_c;
                        state_d = ST_DONE;
                    end else if (sum_c) begin
                        state_d = ST_DONE;
                    end else begin
                        // No end-around carry: A<B, re-complement to get B-A.
                        neg_d   = 1'b1;
                        idx_d   = '0;
                        c_d     = 1'b1;
                        state_d = ST_FIX;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_FIX: begin
                result_d[4*int'(idx_q) +: 4] = sum_dig;
                c_d = sum_c;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            c_q      <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
        end
    end

    assign result = result_q;
    assign ovf    = ovf_q;
    assign neg    = neg_q;
    assign err    = err_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: 2-digit and 4-digit instances checked against
// an integer-arithmetic reference model.
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, opr;
    logic [15:0] a_in, b_in;
    int          sel;
    int          n_vec = 0;
    int          n_fail = 0;

    logic [7:0]  result2;
    logic [15:0] result4;
    logic        ovf2, neg2, err2, busy2, done2, ovf4, neg4, err4, busy4, done4;
    logic        start2, start4;
    logic [15:0] o_result;
    logic        o_ovf, o_neg, o_err, o_busy, o_done;

    always #5 clk = ~clk;

    assign start2 = start && (sel == 2);
    assign start4 = start && (sel == 4);

    bcd_serial_addsub #(.DIGITS(2)) u2 (
        .CLOCK_50(clk), .rst_n(rst_n), .start(start2), .op(opr),
        .a(a_in[7:0]), .b(b_in[7:0]), .result(result2), .ovf(ovf2), .neg(neg2),
        .err(err2), .busy(busy2), .done(done2)
    );

    bcd_serial_addsub #(.DIGITS(4)) u4 (
        .CLOCK_50(clk), .rst_n(rst_n), .start(start4), .op(opr),
        .a(a_in), .b(b_in), .result(result4), .ovf(ovf4), .neg(neg4),
        .err(err4), .busy(busy4), .done(done4)
    );

    always_comb begin
        if (sel == 4) begin
            o_result = result4;
            {o_ovf, o_neg, o_err, o_busy, o_done} = {ovf4, neg4, err4, busy4, done4};
        end else begin
            o_result = {8'h00, result2};
            {o_ovf, o_neg, o_err, o_busy, o_done} = {ovf2, neg2, err2, busy2, done2};
        end
    end

    // Reference: decode to integers, do decimal arithmetic, re-encode.
    function automatic void model(input int nd, input logic opv, input logic [15:0] av,
                                  input logic [15:0] bv, output logic [15:0] r,
                                  output logic ov, output logic ng, output logic er,
                                  output int lat);
        int ai = 0, bi = 0, m = 1, v, da, db;
        er = 1'b0; ov = 1'b0; ng = 1'b0;
        for (int i = 0; i < nd; i++) begin
            da = int'((av >> (4*i)) & 16'hF);
            db = int'((bv >> (4*i)) & 16'hF);
            if (da > 9 || db > 9) er = 1'b1;
            ai += da * m;
            bi += db * m;
            m  *= 10;
        end
        if (er) begin
            v = 0; lat = 1;
        end else if (!opv) begin
            v = ai + bi; ov = (v >= m); v = v % m; lat = nd + 1;
        end else if (ai >= bi) begin
            v = ai - bi; lat = nd + 1;
        end else begin
            v = bi - ai; ng = 1'b1; lat = 2*nd + 1;
        end
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r = r | (16'(v % 10) << (4*i));
            v = v / 10;
        end
    endfunction

    // Waits for idle, issues one operation and returns cycles from accept to done.
    task automatic run_op(input logic opv, input logic [15:0] av, input logic [15:0] bv,
                          output int lat);
        int guard = 0;
        @(negedge clk);
        while (o_busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        opr = opv; a_in = av; b_in = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!o_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        #1;
        for (int s = 2; s <= 4; s += 2) begin
            sel = s; #1;
            n_vec++;
            if ({o_result, o_ovf, o_neg, o_err, o_busy, o_done} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_d%0d: got %h required 0", s,
                         {o_result, o_ovf, o_neg, o_err, o_busy, o_done});
            end
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    int t_sel[8] = '{2, 2, 2, 2, 2, 4, 4, 2};
    int t_op [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    int t_a  [8] = '{'h47, 'h85, 'h47, 'h00, 'h00, 'h9999, 'h1234, 'h4A};
    int t_b  [8] = '{'h85, 'h47, 'h85, 'h00, 'h01, 'h0001, 'h8765, 'h12};
    int t_r  [8] = '{'h32, 'h38, 'h38, 'h00, 'h01, 'h0000, 'h9999, 'h00};
    int t_f  [8] = '{'b100, 'b000, 'b010, 'b000, 'b010, 'b100, 'b000, 'b001};
    int t_l  [8] = '{3, 3, 5, 3, 5, 5, 5, 1};

    task automatic test_directed;
        int lat;
        logic [15:0] r_exp;
        for (int k = 0; k < 8; k++) begin
            sel = t_sel[k];
            run_op(1'(t_op[k]), 16'(t_a[k]), 16'(t_b[k]), lat);
            r_exp = 16'(t_r[k]);
            n_vec++;
            if (o_result !== r_exp || {o_ovf, o_neg, o_err} !== 3'(t_f[k]) || lat != t_l[k]) begin
                n_fail++;
                $display("FAIL directed_%0d: got r=%h flags=%b lat=%0d required r=%h flags=%b lat=%0d",
                         k, o_result, {o_ovf, o_neg, o_err}, lat, r_exp, 3'(t_f[k]), t_l[k]);
            end
            repeat (3) @(posedge clk);
            #1;
            n_vec++;
            if (o_result !== r_exp || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: got r=%h busy=%b required r=%h busy=0",
                         k, o_result, o_busy, r_exp);
            end
        end
    endtask

    task automatic test_random;
        int lat, lat_e;
        logic [15:0] av, bv, r_e;
        logic opv, ov_e, ng_e, er_e;
        for (int k = 0; k < 60; k++) begin
            sel = ($urandom_range(0, 1) == 1) ? 4 : 2;
            av = '0; bv = '0;
            for (int i = 0; i < sel; i++) begin
                av = av | (16'($urandom_range(0, 9)) << (4*i));
                bv = bv | (16'($urandom_range(0, 9)) << (4*i));
            end
            if ($urandom_range(0, 7) == 0)
                av = av | (16'($urandom_range(10, 15)) << (4*$urandom_range(0, sel-1)));
            opv = 1'($urandom_range(0, 1));
            model(sel, opv, av, bv, r_e, ov_e, ng_e, er_e, lat_e);
            run_op(opv, av, bv, lat);
            n_vec++;
            if (o_result !== r_e || {o_ovf, o_neg, o_err} !== {ov_e, ng_e, er_e} || lat != lat_e) begin
                n_fail++;
                $display("FAIL random_%0d d%0d op=%b a=%h b=%h: got r=%h ovf/neg/err=%b lat=%0d required r=%h ovf/neg/err=%b lat=%0d",
                         k, sel, opv, av, bv, o_result, {o_ovf, o_neg, o_err}, lat,
                         r_e, {ov_e, ng_e, er_e}, lat_e);
            end
        end
    endtask

    task automatic test_busy_start;
        int dones = 0;
        sel = 2;
        @(negedge clk);
        opr = 1'b1; a_in = 16'h0047; b_in = 16'h0085; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 15; c++) begin
            if (o_done) dones++;
            @(negedge clk);
            start = (c <= 3);
            opr = 1'b0; a_in = 16'h0011; b_in = 16'h0022;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_vec++;
        if (dones != 1 || o_result !== 16'h0038 || o_neg !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start: got dones=%0d r=%h neg=%b required dones=1 r=0038 neg=1",
                     dones, o_result, o_neg);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        sel = 4;
        run_op(1'b0, 16'h0500, 16'h0600, lat);
        @(negedge clk);
        @(negedge clk);
        opr = 1'b1; a_in = 16'h0300; b_in = 16'h0100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if (o_busy !== 1'b1 || o_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b r=%h required busy=1 r=0000", o_busy, o_result);
        end
        lat = 1;
        while (!o_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (o_result !== 16'h0200 || o_neg !== 1'b0 || lat != 5) begin
            n_fail++;
            $display("FAIL b2b_result: got r=%h neg=%b lat=%0d required r=0200 neg=0 lat=5",
                     o_result, o_neg, lat);
        end
    endtask

    task automatic test_async_reset;
        int lat;
        sel = 4;
        @(negedge clk);
        while (o_busy) @(negedge clk);
        opr = 1'b1; a_in = 16'h0100; b_in = 16'h2000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (o_neg !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_fix: got neg=%b busy=%b required neg=1 busy=1", o_neg, o_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_result, o_ovf, o_neg, o_err, o_busy, o_done} !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h required 0",
                     {o_result, o_ovf, o_neg, o_err, o_busy, o_done});
        end
        @(negedge clk); rst_n = 1'b1;
        run_op(1'b1, 16'h2000, 16'h0100, lat);
        n_vec++;
        if (o_result !== 16'h1900 || o_neg !== 1'b0 || lat != 5) begin
            n_fail++;
            $display("FAIL after_reset: got r=%h neg=%b lat=%0d required r=1900 neg=0 lat=5",
                     o_result, o_neg, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; opr = 1'b0; a_in = '0; b_in = '0; sel = 2;
        test_reset;
        test_directed;
        test_random;
        test_busy_start;
        test_back_to_back;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_serial_addsub.md
# bcd_serial_addsub

Parametrised, digit-serial BCD adder/subtractor for N-digit unsigned decimal operands, the multi-digit successor to the two-digit combinational add/sub datapath behind the board's switch/HEX front end. It processes one BCD digit per clock, least significant digit first, under a start/done handshake. It reports overflow on addition. On subtraction with a negative result, it runs a second serial pass so the output is the magnitude |A−B| with a sign flag, not a raw ten's complement. Invalid (non-BCD) operand digits are rejected with an error flag.

## Interface
- DIGITS, default 4, number of BCD digits per operand and result (≥1).
- CLOCK_50  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = A+B, 1 = A−B; latched with start.
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0].
- b  in  4*DIGITS  operand B, same packing.
- result  out  4*DIGITS  packed BCD result, held until next accepted start.
- ovf  out  1  addition carried out of the top digit; result is the sum mod 10^DIGITS.
- neg  out  1  subtraction with A<B; result holds B−A.
- err  out  1  some digit of A or B exceeded 9; result forced to all zeros.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle on.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: when start=1, latch a, b, op, clear result/ovf/neg/err, set digit index i=0, set carry c=op (1 for subtract).
  - If any latched nibble is >9: next state DONE with err=1.
  - Otherwise next state RUN.
- RUN, one digit per cycle:
  - Let d = b[i] when op=0, else 9−b[i].
  - Binary sum s = a[i] + d + c.
  - If s>9, digit = s+6 (low 4 bits) and c=1. Otherwise digit = s and c=0.
  - Write the digit into result[i] and increment i.
  - After i=DIGITS−1:
    - op=0: ovf = c, go to DONE.
    - op=1 and c=1: A≥B, go to DONE.
    - op=1 and c=0: A<B, set neg=1, i=0, c=1, go to FIX.
- FIX, one digit per cycle: result[i] becomes the BCD value of (9−result[i]) + c with decimal correction, updating c. After i=DIGITS−1, go to DONE. The final carry is discarded.
- DONE: assert done for one cycle, then go to IDLE. result and flags hold until the next accepted start.
- start while busy: ignored, with no queuing.
- The digit index counter has width clog2(DIGITS), minimum 1 bit. It never exceeds DIGITS−1.

## Timing
- Reset, applied at any time (including mid-RUN or mid-FIX): state=IDLE, result=0, ovf=0, neg=0, err=0, busy=0, done=0, i=0, c=0. No partial result survives reset.
- Start accepted on edge T0.
- Add, or subtract with A≥B: RUN occupies cycles T1..T_DIGITS; done is high in cycle DIGITS+1 after T0.
- Subtract with A<B: FIX adds DIGITS cycles; done is high in cycle 2·DIGITS+1.
- err path: done is high in cycle 1 after T0.
- Back-to-back: a start asserted in the cycle after done (the first IDLE cycle) is accepted. Throughput is one operation per DIGITS+2 cycles at best.
- result bits change only during RUN/FIX or on accept. Intermediate digits are visible while busy and must be ignored by the consumer.

## Test plan
- DIGITS=2, op=0, A=47, B=85: expect result=32, ovf=1, neg=0, err=0, and done 3 cycles after start.
- DIGITS=2, op=1, A=85, B=47: expect result=38, neg=0, ovf=0, done at +3. Then A=47, B=85: expect result=38, neg=1, done at +5.
- DIGITS=2, op=1, A=00, B=00: expect result=00, neg=0. A=00, B=01: expect result=01, neg=1.
- DIGITS=4, op=0, A=9999, B=0001: expect result=0000, ovf=1, done at +5. With A=1234, B=8765: expect result=9999, ovf=0.
- DIGITS=2, A=4A (0x4A), B=12, op=0: expect err=1, result=00, done at +1. A start pulsed while busy during a valid operation must be ignored, giving exactly one done.
- DIGITS=4, op=1, A=0100, B=2000: drop rst_n during the FIX pass. All outputs must read 0 immediately (asynchronously), with busy=0. After rst_n rises, a new start for 2000−0100 gives result=1900, neg=0.
